mem_port_arbiter: RTL and testbench

- Arbitrates one shared single-port memory between the instruction-fetch requester (IF1) and the data requester (MEM stage).
- Latches the winning request, drives the memory bus until it acknowledges, then returns read data to the winner.
- Data has priority, with a bounded-starvation guarantee for fetch.
- Also generates byte enables and lane-replicated write data from the RV32I store size (STORE_BYTE/STORE_HALFWORD/STORE_WORD), and flags misaligned data accesses.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 545 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and the data stage.
// Data wins by default; fetch is forced through after MAX_DM_STREAK consecutive data grants.
module mem_port_arbiter #(
   parameter int unsigned MAX_DM_STREAK = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [1:0]  dm_size_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_gnt_o,
   output logic        dm_rvalid_o,
   output logic [31:0] dm_rdata_o,
   output logic        dm_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o,
   output logic        owner_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUS_IF = 2'd1,
      BUS_DM = 2'd2,
      ERR_DM = 2'd3
   } state_t;

   localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DM_STREAK);
   localparam logic [3:0] STREAK_SAT   = 4'hF;

   state_t      state;
   logic [3:0]  streak;
   logic        arb_idle;
   logic        dm_win;
   logic        if_win;
   logic        misaligned;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata_lanes;

   // Grants are suppressed while reset is held so every output reads 0 during reset.
   assign arb_idle = reset_n && (state == IDLE);
   assign dm_win   = arb_idle && dm_req_i && (!if_req_i || (streak < STREAK_LIMIT));
   assign if_win   = arb_idle && if_req_i && !dm_win;
   assign dm_gnt_o = dm_win;
   assign if_gnt_o = if_win;
   assign busy_o   = (state != IDLE);

   assign misaligned = (dm_size_i == 2'd1) ? dm_addr_i[0] :
                       (dm_size_i == 2'd0) ? 1'b0 : (dm_addr_i[1:0] != 2'b00);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      dm_be          = 4'b1111;
      dm_wdata_lanes = dm_wdata_i;
      unique case (dm_size_i)
         2'd0: begin
            dm_be          = 4'b0001 << dm_addr_i[1:0];
            dm_wdata_lanes = {4{dm_wdata_i[7:0]}};
         end
         2'd1: begin
            dm_be          = 4'b0011 << {dm_addr_i[1], 1'b0};
            dm_wdata_lanes = {2{dm_wdata_i[15:0]}};
         end
         default: begin
            dm_be          = 4'b1111;
            dm_wdata_lanes = dm_wdata_i;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         streak      <= 4'd0;
         if_rvalid_o <= 1'b0;
         if_rdata_o  <= 32'd0;
         dm_rvalid_o <= 1'b0;
         dm_rdata_o  <= 32'd0;
         dm_err_o    <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'd0;
         mem_be_o    <= 4'd0;
         mem_wdata_o <= 32'd0;
         owner_o     <= 1'b0;
      end else begin
         // Response strobes are single-cycle pulses; the data registers hold between them.
         if_rvalid_o <= 1'b0;
         dm_rvalid_o <= 1'b0;
         dm_err_o    <= 1'b0;

         unique case (state)
            IDLE: begin
               if (dm_win) begin
                  owner_o     <= 1'b1;
                  mem_we_o    <= dm_we_i;
                  mem_addr_o  <= {dm_addr_i[31:2], 2'b00};
                  mem_be_o    <= dm_be;
                  mem_wdata_o <= dm_we_i ? dm_wdata_lanes : 32'd0;
                  if (misaligned) begin
                     state <= ERR_DM;
                  end else begin
                     state     <= BUS_DM;
                     mem_req_o <= 1'b1;
                  end
               end else if (if_win) begin
                  owner_o     <= 1'b0;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= {if_addr_i[31:2], 2'b00};
                  mem_be_o    <= 4'b1111;
                  mem_wdata_o <= 32'd0;
                  mem_req_o   <= 1'b1;
                  state       <= BUS_IF;
               end

               // Counts data grants that passed over a waiting fetch; anything else clears it.
               if (dm_win && if_req_i) begin
                  streak <= (streak == STREAK_SAT) ? streak : streak + 4'd1;
               end else begin
                  streak <= 4'd0;
               end
            end

            BUS_IF, BUS_DM: begin
               if (mem_ack_i) begin
                  mem_req_o <= 1'b0;
                  state     <= IDLE;
                  if (state == BUS_IF) begin
                     if_rvalid_o <= 1'b1;
                     if_rdata_o  <= mem_rdata_i;
                  end else begin
                     dm_rvalid_o <= 1'b1;
                     dm_rdata_o  <= mem_we_o ? 32'd0 : mem_rdata_i;
                  end
               end
            end

            ERR_DM: begin
               dm_rvalid_o <= 1'b1;
               dm_err_o    <= 1'b1;
               dm_rdata_o  <= 32'd0;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of arbitration, memory contents and lane placement.
module tb_mem_port_arbiter;

   localparam int MAX = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        dm_req_i;
   logic        dm_we_i;
   logic [1:0]  dm_size_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic        dm_gnt_o;
   logic        dm_rvalid_o;
   logic [31:0] dm_rdata_o;
   logic        dm_err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;
   logic        owner_o;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(.MAX_DM_STREAK(MAX)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_size_i(dm_size_i),
      .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
      .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .owner_o(owner_o)
   );

   always #5 clk = ~clk;

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit is_misal(input logic [31:0] a, input logic [1:0] sz);
      return (int'(a[1:0]) % nbytes(sz)) != 0;
   endfunction

   // Byte lanes covered by the access, from the low address bits and the size.
   function automatic logic [3:0] lanes(input logic [31:0] a, input logic [1:0] sz);
      logic [3:0] be;
      int lo;
      lo = int'(a[1:0]);
      be = 4'd0;
      for (int k = 0; k < 4; k++) be[k] = (k >= lo) && (k < lo + nbytes(sz));
      return be;
   endfunction

   function automatic logic [31:0] replicate(input logic [31:0] w, input logic [1:0] sz);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(k % nbytes(sz)) +: 8];
      return r;
   endfunction

   task automatic clear_inputs();
      if_req_i    = 1'b0;
      if_addr_i   = 32'd0;
      dm_req_i    = 1'b0;
      dm_we_i     = 1'b0;
      dm_size_i   = 2'd0;
      dm_addr_i   = 32'd0;
      dm_wdata_i  = 32'd0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      if_req_i = 1'b1;
      dm_req_i = 1'b1;
      #1;
      total++;
      if ({if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, busy_o, owner_o} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got gnt=%b/%b req=%b busy=%b addr=%h required all zero",
                  if_gnt_o, dm_gnt_o, mem_req_o, busy_o, mem_addr_o);
      end
      clear_inputs();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_fetch();
      do_reset();
      @(negedge clk);
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0106;
      #1;
      total++;
      if ({if_gnt_o, dm_gnt_o} !== 2'b10) begin
         bad++; $display("FAIL fetch_gnt: got %b required 10", {if_gnt_o, dm_gnt_o});
      end
      @(negedge clk);
      if_req_i = 1'b0;
      #1;
      total++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, busy_o, owner_o} !==
          {1'b1, 1'b0, 32'h0000_0104, 4'hF, 32'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL fetch_bus: got req=%b we=%b addr=%h be=%h wd=%h required 1 0 00000104 f 0",
                  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o);
      end
      @(negedge clk);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h0010_0093;
      @(negedge clk);
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'h5555_5555;
      #1;
      total++;
      if ({if_rvalid_o, if_rdata_o, dm_rvalid_o, mem_req_o, busy_o} !== {1'b1, 32'h0010_0093, 3'b000}) begin
         bad++;
         $display("FAIL fetch_rvalid: got rv=%b data=%h dmrv=%b req=%b busy=%b required 1 00100093 0 0 0",
                  if_rvalid_o, if_rdata_o, dm_rvalid_o, mem_req_o, busy_o);
      end
      @(negedge clk);
      #1;
      total++;
      if ({if_rvalid_o, if_rdata_o} !== {1'b0, 32'h0010_0093}) begin
         bad++; $display("FAIL fetch_hold: got rv=%b data=%h required 0 00100093", if_rvalid_o, if_rdata_o);
      end
   endtask

   task automatic test_store_byte();
      do_reset();
      @(negedge clk);
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_size_i  = 2'd0;
      dm_addr_i  = 32'h0000_2003;
      dm_wdata_i = 32'h0000_00AB;
      #1;
      total++;
      if ({if_gnt_o, dm_gnt_o} !== 2'b01) begin
         bad++; $display("FAIL sb_gnt: got %b required 01", {if_gnt_o, dm_gnt_o});
      end
      @(negedge clk);
      dm_req_i    = 1'b0;
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hDEAD_BEEF;
      #1;
      total++;
      if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, owner_o} !==
          {1'b1, 1'b1, 32'h0000_2000, 4'b1000, 32'hABAB_ABAB, 1'b1}) begin
         bad++;
         $display("FAIL sb_bus: got req=%b we=%b addr=%h be=%b wd=%h own=%b required 1 1 00002000 1000 abababab 1",
                  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, owner_o);
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
      #1;
      total++;
      if ({dm_rvalid_o, dm_err_o, dm_rdata_o, if_rvalid_o} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
         bad++;
         $display("FAIL sb_rvalid: got rv=%b err=%b data=%h required 1 0 00000000",
                  dm_rvalid_o, dm_err_o, dm_rdata_o);
      end
   endtask

   task automatic test_misaligned();
      do_reset();
      @(negedge clk);
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_size_i  = 2'd1;
      dm_addr_i  = 32'h0000_1001;
      dm_wdata_i = 32'h0000_BEEF;
      #1;
      total++;
      if (dm_gnt_o !== 1'b1) begin
         bad++; $display("FAIL mis_gnt: got %b required 1", dm_gnt_o);
      end
      @(negedge clk);
      dm_req_i  = 1'b0;
      mem_ack_i = 1'b1;
      #1;
      total++;
      if ({mem_req_o, dm_rvalid_o, busy_o} !== 3'b001) begin
         bad++; $display("FAIL mis_err_state: got req=%b rv=%b busy=%b required 0 0 1", mem_req_o, dm_rvalid_o, busy_o);
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
      #1;
      total++;
      if ({dm_rvalid_o, dm_err_o, dm_rdata_o, mem_req_o} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin
         bad++;
         $display("FAIL mis_rvalid: got rv=%b err=%b data=%h req=%b required 1 1 0 0",
                  dm_rvalid_o, dm_err_o, dm_rdata_o, mem_req_o);
      end
      @(negedge clk);
      #1;
      total++;
      if ({dm_rvalid_o, dm_err_o, mem_req_o} !== 3'b000) begin
         bad++; $display("FAIL mis_pulse: got rv=%b err=%b req=%b required 0 0 0", dm_rvalid_o, dm_err_o, mem_req_o);
      end
   endtask

   task automatic test_stretched_ack();
      do_reset();
      @(negedge clk);
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_size_i  = 2'd2;
      dm_addr_i  = 32'h0000_3008;
      dm_wdata_i = 32'hCAFE_F00D;
      #1;
      total++;
      if ({if_gnt_o, dm_gnt_o} !== 2'b01) begin
         bad++; $display("FAIL stretch_gnt: got %b required 01", {if_gnt_o, dm_gnt_o});
      end
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         dm_req_i  = 1'b0;
         if_req_i  = 1'b1;
         if_addr_i = 32'h0000_0500;
         mem_ack_i = (k == 6);
         #1;
         total++;
         if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !==
             {1'b1, 1'b1, 32'h0000_3008, 4'hF, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL stretch_stable cycle %0d: got req=%b addr=%h be=%h wd=%h required 1 00003008 f cafef00d",
                     k, mem_req_o, mem_addr_o, mem_be_o, mem_wdata_o);
         end
         total++;
         if (if_gnt_o !== 1'b0) begin
            bad++; $display("FAIL stretch_no_gnt cycle %0d: got %b required 0", k, if_gnt_o);
         end
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
      #1;
      total++;
      if ({dm_rvalid_o, dm_err_o, dm_rdata_o, if_gnt_o} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
         bad++;
         $display("FAIL stretch_done: got rv=%b err=%b data=%h ifgnt=%b required 1 0 0 1",
                  dm_rvalid_o, dm_err_o, dm_rdata_o, if_gnt_o);
      end
      @(negedge clk);
      if_req_i = 1'b0;
      #1;
      total++;
      if ({mem_req_o, mem_addr_o, owner_o} !== {1'b1, 32'h0000_0500, 1'b0}) begin
         bad++; $display("FAIL stretch_fetch: got req=%b addr=%h own=%b required 1 00000500 0", mem_req_o, mem_addr_o, owner_o);
      end
   endtask

   task automatic test_streak();
      string seq;
      int    g;
      do_reset();
      seq = "";
      g   = 0;
      for (int c = 0; c < 300 && g < 10; c++) begin
         @(negedge clk);
         if_req_i    = 1'b1;
         if_addr_i   = 32'h0000_0100;
         dm_req_i    = 1'b1;
         dm_we_i     = 1'b0;
         dm_size_i   = 2'd2;
         dm_addr_i   = 32'h0000_0200;
         mem_ack_i   = mem_req_o;
         mem_rdata_i = $urandom;
         #1;
         total++;
         if (if_gnt_o && dm_gnt_o) begin
            bad++; $display("FAIL streak_double_gnt: got if=1 dm=1 required at most one");
         end
         if (dm_gnt_o) begin
            seq = {seq, "D"}; g++;
         end else if (if_gnt_o) begin
            seq = {seq, "I"}; g++;
         end
      end
      total++;
      if (seq != "DDDDIDDDDI") begin
         bad++; $display("FAIL streak_order: got %s required DDDDIDDDDI", seq);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b1;
      dm_size_i  = 2'd2;
      dm_addr_i  = 32'h0000_0044;
      dm_wdata_i = 32'h1234_5678;
      @(negedge clk);
      dm_req_i = 1'b0;
      #1;
      total++;
      if ({mem_req_o, busy_o} !== 2'b11) begin
         bad++; $display("FAIL rmid_inflight: got req=%b busy=%b required 1 1", mem_req_o, busy_o);
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++;
      if ({if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, busy_o, owner_o} !== '0) begin
         bad++;
         $display("FAIL rmid_outputs: got req=%b we=%b addr=%h be=%h wd=%h busy=%b required all zero",
                  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, busy_o);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         mem_ack_i = (k % 2 == 0);
         #1;
         total++;
         if ({dm_rvalid_o, if_rvalid_o, mem_req_o} !== 3'b000) begin
            bad++; $display("FAIL rmid_no_rvalid: got dmrv=%b ifrv=%b req=%b required 0 0 0", dm_rvalid_o, if_rvalid_o, mem_req_o);
         end
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0020;
      #1;
      total++;
      if ({if_gnt_o, dm_gnt_o} !== 2'b10) begin
         bad++; $display("FAIL rmid_rearb: got %b required 10", {if_gnt_o, dm_gnt_o});
      end
   endtask

   task automatic test_random();
      logic [31:0] mem_model [64];
      logic [31:0] ia, da, dw, e_addr, e_wdata, e_rdata, last_if, last_dm, g_addr, g_wdata;
      logic [1:0]  dsz, g_size;
      logic [3:0]  e_be;
      logic        dwe, e_we;
      bit          if_pend, dm_pend, out, o_dm, o_err, seen_if, seen_dm;
      bit          bus_phase, ack, exp_rv, dm_wins, if_wins;
      int          gnt_cyc, rv_cyc, ack_wait, passed, lo, n;

      do_reset();
      for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
      ia = 32'd0; da = 32'd0; dw = 32'd0; dsz = 2'd0; dwe = 1'b0;
      e_addr = 32'd0; e_wdata = 32'd0; e_rdata = 32'd0; e_be = 4'd0; e_we = 1'b0;
      g_addr = 32'd0; g_wdata = 32'd0; g_size = 2'd0;
      last_if = 32'd0; last_dm = 32'd0;
      if_pend = 0; dm_pend = 0; out = 0; o_dm = 0; o_err = 0; seen_if = 0; seen_dm = 0;
      gnt_cyc = 0; rv_cyc = -1; ack_wait = 0; passed = 0;

      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (!if_pend && $urandom_range(0, 3) != 0) begin
            if_pend = 1;
            ia      = $urandom;
         end
         if (!dm_pend && $urandom_range(0, 3) != 0) begin
            dm_pend = 1;
            da      = $urandom;
            dsz     = 2'($urandom_range(0, 3));
            dwe     = 1'($urandom_range(0, 1));
            dw      = $urandom;
            if ($urandom_range(0, 3) != 0) da[1:0] = 2'(int'(da[1:0]) / nbytes(dsz) * nbytes(dsz));
         end

         bus_phase = out && !o_err && (t > gnt_cyc) && (rv_cyc < 0);
         if (bus_phase) begin
            ack = (ack_wait == 0);
            if (ack_wait > 0) ack_wait--;
         end else begin
            ack = ($urandom_range(0, 3) == 0);
         end

         if_req_i    = if_pend;
         if_addr_i   = ia;
         dm_req_i    = dm_pend;
         dm_we_i     = dwe;
         dm_size_i   = dsz;
         dm_addr_i   = da;
         dm_wdata_i  = dw;
         mem_ack_i   = ack;
         mem_rdata_i = bus_phase ? mem_model[e_addr[7:2]] : $urandom;
         #1;

         exp_rv = out && (t == rv_cyc);
         total++;
         if ({if_rvalid_o, dm_rvalid_o} !== {exp_rv && !o_dm, exp_rv && o_dm}) begin
            bad++;
            $display("FAIL rnd_rvalid t=%0d: got if=%b dm=%b required if=%b dm=%b",
                     t, if_rvalid_o, dm_rvalid_o, exp_rv && !o_dm, exp_rv && o_dm);
         end
         if (exp_rv) begin
            total++;
            if (o_dm) begin
               if ({dm_rdata_o, dm_err_o} !== {e_rdata, o_err}) begin
                  bad++;
                  $display("FAIL rnd_dm_resp t=%0d: got data=%h err=%b required data=%h err=%b",
                           t, dm_rdata_o, dm_err_o, e_rdata, o_err);
               end
               last_dm = e_rdata;
               seen_dm = 1;
            end else begin
               if (if_rdata_o !== e_rdata) begin
                  bad++; $display("FAIL rnd_if_resp t=%0d: got %h required %h", t, if_rdata_o, e_rdata);
               end
               last_if = e_rdata;
               seen_if = 1;
            end
            out = 0;
         end else begin
            total++;
            if (dm_err_o !== 1'b0) begin
               bad++; $display("FAIL rnd_err_idle t=%0d: got %b required 0", t, dm_err_o);
            end
            if (seen_if) begin
               total++;
               if (if_rdata_o !== last_if) begin
                  bad++; $display("FAIL rnd_if_hold t=%0d: got %h required %h", t, if_rdata_o, last_if);
               end
            end
            if (seen_dm) begin
               total++;
               if (dm_rdata_o !== last_dm) begin
                  bad++; $display("FAIL rnd_dm_hold t=%0d: got %h required %h", t, dm_rdata_o, last_dm);
               end
            end
         end

         total++;
         if (busy_o !== out || (out && owner_o !== o_dm)) begin
            bad++;
            $display("FAIL rnd_busy t=%0d: got busy=%b own=%b required busy=%b own=%b", t, busy_o, owner_o, out, o_dm);
         end

         total++;
         if (mem_req_o !== bus_phase) begin
            bad++; $display("FAIL rnd_mem_req t=%0d: got %b required %b", t, mem_req_o, bus_phase);
         end
         if (bus_phase) begin
            total++;
            if ({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== {e_we, e_addr, e_be, e_wdata}) begin
               bad++;
               $display("FAIL rnd_bus t=%0d: got we=%b addr=%h be=%b wd=%h required we=%b addr=%h be=%b wd=%h",
                        t, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, e_we, e_addr, e_be, e_wdata);
            end
            if (ack) begin
               if (o_dm && e_we) begin
                  lo = int'(g_addr[1:0]);
                  n  = nbytes(g_size);
                  for (int k = 0; k < n; k++) mem_model[g_addr[7:2]][8*(lo+k) +: 8] = g_wdata[8*k +: 8];
                  e_rdata = 32'd0;
               end else begin
                  e_rdata = mem_model[e_addr[7:2]];
               end
               rv_cyc = t + 1;
            end
         end

         if (!out) begin
            dm_wins = dm_pend && (!if_pend || passed < MAX);
            if_wins = if_pend && !dm_wins;
            total++;
            if ({if_gnt_o, dm_gnt_o} !== {if_wins, dm_wins}) begin
               bad++;
               $display("FAIL rnd_arb t=%0d: got if=%b dm=%b required if=%b dm=%b passed=%0d",
                        t, if_gnt_o, dm_gnt_o, if_wins, dm_wins, passed);
            end
            passed = (dm_wins && if_pend) ? passed + 1 : 0;
            if (dm_wins || if_wins) begin
               out      = 1;
               o_dm     = dm_wins;
               o_err    = 0;
               gnt_cyc  = t;
               rv_cyc   = -1;
               ack_wait = $urandom_range(0, 3);
               e_rdata  = 32'd0;
               if (dm_wins) begin
                  g_addr  = da;
                  g_size  = dsz;
                  g_wdata = dw;
                  o_err   = is_misal(da, dsz);
                  if (o_err) rv_cyc = t + 2;
                  e_we    = dwe;
                  e_addr  = {da[31:2], 2'b00};
                  e_be    = lanes(da, dsz);
                  e_wdata = dwe ? replicate(dw, dsz) : 32'd0;
                  dm_pend = 0;
               end else begin
                  e_we    = 1'b0;
                  e_addr  = {ia[31:2], 2'b00};
                  e_be    = 4'hF;
                  e_wdata = 32'd0;
                  if_pend = 0;
               end
            end
         end else begin
            total++;
            if ({if_gnt_o, dm_gnt_o} !== 2'b00) begin
               bad++; $display("FAIL rnd_busy_gnt t=%0d: got %b required 00", t, {if_gnt_o, dm_gnt_o});
            end
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_fetch();
      test_store_byte();
      test_misaligned();
      test_stretched_ack();
      test_streak();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
